// File: rtl/grid_read_server.sv
`default_nettype none
// ============================================================================
//  Module      : grid_read_server
//  Description : Grid-map read responder. Two requesters (A = render/DDA,
//                B = movement/collision) share one synchronous BRAM through
//                a pipelined, arbitrated read path. The block also owns the
//                map-select switch and drains in-flight reads first, so no
//                response mixes data from two maps.
//                Optional feature macro: GRID_OOB_WALL_EN (an address past
//                the last cell returns a wall instead of reading the BRAM).
//  Revision    : 1.0 - initial release
// ============================================================================
module grid_read_server #(
    parameter int N            = 24,
    parameter int ADDR_W       = $clog2(N * N),
    parameter int DATA_W       = 5,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic [1:0]          map_select,
    input  logic                a_req_in,
    input  logic [ADDR_W-1:0]   a_address_in,
    output logic                a_valid_out,
    output logic [DATA_W-1:0]   a_data_out,
    input  logic                b_req_in,
    input  logic [ADDR_W-1:0]   b_address_in,
    output logic                b_valid_out,
    output logic [DATA_W-1:0]   b_data_out,
    output logic                mem_en_out,
    output logic [ADDR_W+1:0]   mem_addr_out,
    input  logic [DATA_W-1:0]   mem_data_in,
    output logic                busy_out
);

    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [DATA_W-1:0] WALL       = DATA_W'(1);
    localparam int                LAST       = MEM_LATENCY - 1;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [1:0]             map_sel_q;

    logic                   a_pend;
    logic                   b_pend;
    logic [ADDR_W-1:0]      a_addr;
    logic [ADDR_W-1:0]      b_addr;
    logic [SC_W-1:0]        starve_cnt;

    // Tag pipeline: one entry per cycle of BRAM latency. Port bit: 0 = A, 1 = B.
    logic [MEM_LATENCY-1:0] tag_v;
    logic [MEM_LATENCY-1:0] tag_port;
    logic [MEM_LATENCY-1:0] tag_oob;

    logic                   run_state;
    logic                   switch_state;
    logic                   sel_match;
    logic                   grant_ok;
    logic                   b_forced;
    logic                   grant_a;
    logic                   grant_b;
    logic                   grant_any;
    logic                   grant_oob;
    logic [ADDR_W-1:0]      grant_addr;
    logic                   a_inflight;
    logic                   b_inflight;
    logic                   a_accept;
    logic                   b_accept;
    logic                   tags_busy;

    // Arbitration: A by default, B once it has waited long enough.
    always_comb begin
        sel_match  = (map_select == map_sel_q);
        grant_ok   = run_state && sel_match && !rst_in;
        b_forced   = b_pend && (starve_cnt >= STARVE_MAX);
        grant_b    = grant_ok && b_pend && (b_forced || !a_pend);
        grant_a    = grant_ok && a_pend && !grant_b;
        grant_any  = grant_a || grant_b;
        grant_addr = grant_b ? b_addr : a_addr;
    end

`ifdef GRID_OOB_WALL_EN
    localparam logic [ADDR_W:0] CELL_COUNT = (ADDR_W + 1)'(N * N);
    assign grant_oob = grant_any && ({1'b0, grant_addr} >= CELL_COUNT);
`else
    assign grant_oob = 1'b0;
`endif

    assign tags_busy    = |tag_v;
    assign a_inflight   = |(tag_v & ~tag_port);
    assign b_inflight   = |(tag_v & tag_port);
    // A request is ignored once its port has a granted read outstanding.
    assign a_accept     = a_req_in && !grant_a && !a_inflight;
    assign b_accept     = b_req_in && !grant_b && !b_inflight;

    assign mem_en_out   = grant_any && !grant_oob;
    assign mem_addr_out = grant_any ? {map_sel_q, grant_addr} : '0;
    assign busy_out     = a_pend || b_pend || tags_busy || !run_state;

    // Map-switch state register.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Stop granting on a select change, wait for the pipeline to empty, then swap.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (!sel_match) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!tags_busy) state_nxt = ST_SWITCH;
            ST_SWITCH: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // State decode used by the datapath.
    always_comb begin
        run_state    = (state == ST_RUN);
        switch_state = (state == ST_SWITCH);
    end

    // Active map; takes whatever select is present in the switch cycle.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            map_sel_q <= map_select;
        end else if (switch_state) begin
            map_sel_q <= map_select;
        end
    end

    // Per-port pending flag and latched address.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            a_pend <= 1'b0;
            b_pend <= 1'b0;
            a_addr <= '0;
            b_addr <= '0;
        end else begin
            if (grant_a) begin
                a_pend <= 1'b0;
            end else if (a_accept) begin
                a_pend <= 1'b1;
                a_addr <= a_address_in;
            end
            if (grant_b) begin
                b_pend <= 1'b0;
            end else if (b_accept) begin
                b_pend <= 1'b1;
                b_addr <= b_address_in;
            end
        end
    end

    // Count cycles B waits while pending; saturates at the limit.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            starve_cnt <= '0;
        end else if (grant_b) begin
            starve_cnt <= '0;
        end else if (b_pend && (starve_cnt < STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Tag shift register tracking each grant through the BRAM latency.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            tag_v    <= '0;
            tag_port <= '0;
            tag_oob  <= '0;
        end else begin
            tag_v[0]    <= grant_any;
            tag_port[0] <= grant_b;
            tag_oob[0]  <= grant_oob;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_v[i]    <= tag_v[i-1];
                tag_port[i] <= tag_port[i-1];
                tag_oob[i]  <= tag_oob[i-1];
            end
        end
    end

    // Response stage: capture BRAM data into the owning port for one cycle.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            a_valid_out <= 1'b0;
            b_valid_out <= 1'b0;
            a_data_out  <= '0;
            b_data_out  <= '0;
        end else begin
            a_valid_out <= tag_v[LAST] && !tag_port[LAST];
            b_valid_out <= tag_v[LAST] && tag_port[LAST];
            if (tag_v[LAST] && !tag_port[LAST]) begin
                a_data_out <= tag_oob[LAST] ? WALL : mem_data_in;
            end
            if (tag_v[LAST] && tag_port[LAST]) begin
                b_data_out <= tag_oob[LAST] ? WALL : mem_data_in;
            end
        end
    end

endmodule
`default_nettype wire
